// File: rtl/rf_pkg.sv
// Shared defaults and state encoding for the parametrised integer register file.
// Pure declarations, no logic; no latency.
// No handshake of its own; consumers stall on busy.
package rf_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          NREGS_DEF   = 32;
    localparam int          SP_IDX_DEF  = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_03FC;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks entries 1..NREGS-1 after reset, then releases the file.
// One entry per edge; busy falls after exactly NREGS-1 edges past reset release.
// No backpressure: the core must stall while busy is high.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    // State and index registers; reset restarts the clear at entry 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: leave CLEAR once the last entry is being written; RUN is sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_idx_q == LAST_IDX) begin
            state_d = RUN;
        end
    end

    // Index advance while clearing; parks on the last entry so it never wraps.
    always_comb begin
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR && clr_idx_q != LAST_IDX) begin
            clr_idx_d = clr_idx_q + 1'b1;
        end
    end

    // Outputs: clear writes only happen on edges where reset is low.
    always_comb begin
        busy    = (state_q == CLEAR);
        clr_we  = (state_q == CLEAR) && !reset;
        clr_idx = clr_idx_q;
    end

endmodule

// File: rtl/rf_param.sv
// Parametrised 2-read/1-write integer register file with clear sequencer and bypass.
// Reads are 0 cycles (READ_REG=0) or 1 edge (READ_REG=1); writes land on the edge.
// Writes and reads are ignored/zeroed while busy; the core must stall on busy.
module rf_param
    import rf_pkg::*;
#(
    parameter int          XLEN     = XLEN_DEF,
    parameter int          NREGS    = NREGS_DEF,
    parameter int          AW       = 5,
    parameter int          READ_REG = 0,
    parameter int          BYPASS   = 1,
    parameter int          SP_IDX   = SP_IDX_DEF,
    parameter logic [31:0] SP_INIT  = SP_INIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy
);

    localparam bit              SP_EN     = (SP_IDX != 0) && (SP_IDX < NREGS);
    localparam logic [AW-1:0]   SP_ADDR   = AW'(SP_IDX);
    localparam logic [XLEN-1:0] SP_VAL    = XLEN'(SP_INIT);
    localparam logic [AW:0]     NREGS_EXT = (AW + 1)'(NREGS);

    logic            seq_busy;
    logic            clr_we;
    logic [AW-1:0]   clr_idx;
    logic            run;
    logic            user_we;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [AW-1:0]   ra   [2];
    logic [XLEN-1:0] rd_c [2];

    rf_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .busy    (seq_busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign run   = !seq_busy;
    assign busy  = seq_busy;
    assign ra[0] = ra1;
    assign ra[1] = ra2;

    // A user write counts only in RUN, to a non-zero in-range entry.
    always_comb begin
        user_we = run && we && (waddr != '0) && ({1'b0, waddr} < NREGS_EXT);
    end

    // Single write port: the clear sequencer owns it while clearing.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx;
            wr_data = (SP_EN && clr_idx == SP_ADDR) ? SP_VAL : '0;
        end else if (user_we) begin
            wr_en = 1'b1;
        end
    end

    // Array storage; deliberately not reset, the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data: zero while busy or for entry 0 / out-of-range, else bypass or array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_c[p] = '0;
            if (run && ra[p] != '0 && {1'b0, ra[p]} < NREGS_EXT) begin
                if (BYPASS != 0 && user_we && waddr == ra[p]) begin
                    rd_c[p] = wdata;
                end else begin
                    rd_c[p] = mem_q[ra[p]];
                end
            end
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

        // Output register input: rd_c is already 0 during CLEAR, so the register holds 0 then.
        always_comb begin
            rd1_d = rd_c[0];
            rd2_d = rd_c[1];
        end

        // Output registers load every edge and clear asynchronously on reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
            end
        end

        assign rd1 = rd1_q;
        assign rd2 = rd2_q;
    end else begin : g_rd_comb
        assign rd1 = rd_c[0];
        assign rd2 = rd_c[1];
    end

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: three instances share stimulus (comb+bypass, comb no bypass, registered+bypass).
module tb_rf_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        busy_a, busy_b, busy_c;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rf_param #(.READ_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a), .busy(busy_a));

    rf_param #(.READ_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b));

    rf_param #(.READ_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c), .busy(busy_c));

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] a1, a2;   // comb + bypass
        logic [31:0] b1, b2;   // comb, no bypass
        logic [31:0] c1, c2;   // registered + bypass, after the edge
    } vec_t;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    vec_t vecs [9];
    exp_t sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges after reset release until busy drops; bounded at 40.
    task automatic count_clear(input string name);
        int cnt;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            cnt = i;
            if (!busy_a) break;
        end
        chk({name, "_edges"}, 32'(cnt), 32'd31);
        chk({name, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        chk({name, "_busy_b"}, {31'd0, busy_b}, 32'd0);
        chk({name, "_busy_c"}, {31'd0, busy_c}, 32'd0);
    endtask

    initial begin
        exp_t e;
        exp_t prev;

        vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd5,  32'h3FC,      32'h0,        32'h3FC,      32'h0,        32'h3FC,      32'h0};
        vecs[1] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd4,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd9,  32'h12345678, 5'd9,  5'd9,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd7,  32'h5,        5'd7,  5'd2,  32'h5,        32'h3FC,      32'hDEADBEEF, 32'h3FC,      32'h5,        32'h3FC};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h5,        32'h0,        32'h5,        32'h0,        32'h5,        32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'hAAAA5555, 5'd31, 5'd1,  32'hAAAA5555, 32'h0,        32'h0,        32'h0,        32'hAAAA5555, 32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};

        // Reset held, with a write to x4 pending that must never land.
        reset = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h1; ra1 = 5'd2; ra2 = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
        chk("rst_busy_c", {31'd0, busy_c}, 32'd1);
        chk("rst_rd1_a", rd1_a, 32'h0);
        chk("rst_rd1_b", rd1_b, 32'h0);
        chk("rst_rd1_c", rd1_c, 32'h0);
        chk("rst_rd2_c", rd2_c, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        count_clear("clear1");
        we = 1'b0;

        // Table: comb ports checked before the edge, registered port through the scoreboard.
        prev = '{32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            sbq.push_back('{vecs[i].c1, vecs[i].c2});
            #1;
            chk($sformatf("v%0d_a_rd1", i), rd1_a, vecs[i].a1);
            chk($sformatf("v%0d_a_rd2", i), rd2_a, vecs[i].a2);
            chk($sformatf("v%0d_b_rd1", i), rd1_b, vecs[i].b1);
            chk($sformatf("v%0d_b_rd2", i), rd2_b, vecs[i].b2);
            chk($sformatf("v%0d_c_pre_rd1", i), rd1_c, prev.r1);
            chk($sformatf("v%0d_c_pre_rd2", i), rd2_c, prev.r2);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d_c_rd1", i), rd1_c, e.r1);
            chk($sformatf("v%0d_c_rd2", i), rd2_c, e.r2);
            prev = e;
        end

        // Asynchronous reset mid-run: outputs and busy react without a clock edge.
        @(negedge clk);
        we = 1'b0; ra1 = 5'd7; ra2 = 5'd9;
        #1;
        chk("run_rd1_a", rd1_a, 32'h5);
        chk("run_rd2_a", rd2_a, 32'h12345678);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy_a", {31'd0, busy_a}, 32'd1);
        chk("arst_busy_c", {31'd0, busy_c}, 32'd1);
        chk("arst_rd1_a", rd1_a, 32'h0);
        chk("arst_rd2_b", rd2_b, 32'h0);
        chk("arst_rd1_c", rd1_c, 32'h0);
        chk("arst_rd2_c", rd2_c, 32'h0);

        // Release, let the clear reach entry 10, then reset again mid-clear.
        @(negedge clk);
        reset = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_busy_a", {31'd0, busy_a}, 32'd1);
        chk("mid_rd1_c", rd1_c, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        count_clear("clear2");

        // Array fully re-cleared, stack pointer preloaded again.
        ra1 = 5'd7; ra2 = 5'd2;
        #1;
        chk("post_x7_a", rd1_a, 32'h0);
        chk("post_x2_a", rd2_a, 32'h3FC);
        chk("post_x7_b", rd1_b, 32'h0);
        chk("post_x2_b", rd2_b, 32'h3FC);
        @(posedge clk);
        #1;
        chk("post_x7_c", rd1_c, 32'h0);
        chk("post_x2_c", rd2_c, 32'h3FC);
        ra1 = 5'd9; ra2 = 5'd4;
        #1;
        chk("post_x9_a", rd1_a, 32'h0);
        chk("post_x4_a", rd2_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
